arbiter_rejestr: RTL and testbench

Round-robin access controller for the 8×8-bit general register bank. It shares the bank's single read port (select plus read enable into the read multiplexer) and single write port among up to N_REQ requesters: the CPU core, the PLC scan/IO unit and the debug port. Each transaction is a full request/grant/acknowledge handshake, so requesters never drive the register bank directly.

---
 rtl/arbiter_rejestr_pkg.sv | 23 ++
 rtl/arbiter_rejestr_rr_priority.sv | 35 +++
 rtl/arbiter_rejestr.sv | 114 +++++++++++
 tb/tb_arbiter_rejestr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arbiter_rejestr_pkg.sv
// Shared definitions for the general register bank and its access arbiter:
// FSM state codes, default bank geometry and a modulo increment helper.
package rejestr_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int REG_DATA_W = 8;
    localparam int REG_ADDR_W = 3;
    localparam int REG_COUNT  = 8;

    typedef enum logic [1:0] {
        STATE_IDLE   = ST_IDLE,
        STATE_ACCESS = ST_ACCESS,
        STATE_DONE   = ST_DONE
    } state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbiter_rejestr_rr_priority.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// modulo N_REQ. Shared with the bus arbiter.
module rr_priority #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int               c;
    logic [PTR_W-1:0] cidx;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        c      = 0;
        cidx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            c    = (int'(ptr) + off) % N_REQ;
            cidx = PTR_W'(c);
            if (req[cidx]) begin
                onehot = N_REQ'(1) << c;
                idx    = cidx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_rejestr.sv
// Round-robin arbiter sharing the register bank's read and write ports among
// N_REQ requesters with a req/gnt/ack handshake, one transaction per 3 cycles.
module arbiter_rejestr
    import rejestr_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        rf_sel,
    output logic                     rf_read_enable,
    input  logic [DATA_W-1:0]        rf_rdata,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_idx;
    logic               lat_we;

    logic [N_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    logic [ADDR_W-1:0]  addr_a  [N_REQ];
    logic [DATA_W-1:0]  wdata_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_priority #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The rf_* registers double as the latched addr/wdata of the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= STATE_IDLE;
            ptr            <= '0;
            win_idx        <= '0;
            lat_we         <= 1'b0;
            gnt            <= '0;
            ack            <= '0;
            rdata          <= '0;
            rf_sel         <= '0;
            rf_read_enable <= 1'b0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
        end else begin
            unique case (state)
                STATE_IDLE: begin
                    ack <= '0;
                    if (pick_any) begin
                        state   <= STATE_ACCESS;
                        win_idx <= pick_idx;
                        lat_we  <= we[pick_idx];
                        gnt     <= pick_onehot;
                        if (we[pick_idx]) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= addr_a[pick_idx];
                            rf_wdata <= wdata_a[pick_idx];
                        end else begin
                            rf_sel         <= addr_a[pick_idx];
                            rf_read_enable <= 1'b1;
                        end
                    end
                end
                STATE_ACCESS: begin
                    if (!lat_we) rdata <= rf_rdata;
                    ack            <= gnt;
                    rf_sel         <= '0;
                    rf_read_enable <= 1'b0;
                    rf_we          <= 1'b0;
                    rf_waddr       <= '0;
                    rf_wdata       <= '0;
                    state          <= STATE_DONE;
                end
                STATE_DONE: begin
                    ack   <= '0;
                    gnt   <= '0;
                    ptr   <= PTR_W'(wrap_inc(int'(win_idx), N_REQ));
                    state <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_rejestr.sv
// Directed bench for arbiter_rejestr with a behavioural 8x8 register bank.
module tb_arbiter_rejestr;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [8:0]  addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [7:0]  rdata;
    logic [2:0]  rf_sel;
    logic        rf_read_enable;
    logic [7:0]  rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;

    logic [7:0]  bank [8];
    logic        init_bank;

    int tests;
    int fails;

    arbiter_rejestr #(.N_REQ(3), .DATA_W(8), .ADDR_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .ack            (ack),
        .rdata          (rdata),
        .rf_sel         (rf_sel),
        .rf_read_enable (rf_read_enable),
        .rf_rdata       (rf_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank contents after init: r5 = A7, otherwise {i, 15-i}.
    assign rf_rdata = bank[rf_sel];
    always @(posedge clk) begin
        if (init_bank) begin
            for (int i = 0; i < 8; i++)
                bank[i] <= (i == 5) ? 8'hA7 : {4'(i), 4'(15 - i)};
        end else if (rf_we) begin
            bank[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [8:0]  addr;
        logic [23:0] wdata;
        int          win;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [8:0] a,
                                input logic [23:0] d, input int win, input logic [7:0] rd);
        vec_t v;
        v.req = r; v.we = w; v.addr = a; v.wdata = d; v.win = win; v.rdata = rd;
        return v;
    endfunction

    task automatic run_vec(input int n, input vec_t v);
        logic [2:0] eg;
        logic [2:0] ea;
        logic [7:0] ed;
        logic       ew;
        eg = 3'b001 << v.win;
        ea = 3'((v.addr >> (3 * v.win)) & 9'h7);
        ed = 8'((v.wdata >> (8 * v.win)) & 24'hFF);
        ew = v.we[v.win];
        req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d gnt", n), 32'(gnt), 32'(eg));
        chk($sformatf("v%0d ack_access", n), 32'(ack), 32'd0);
        chk($sformatf("v%0d rf_we", n), 32'(rf_we), 32'(ew));
        chk($sformatf("v%0d rf_read_enable", n), 32'(rf_read_enable), 32'(!ew));
        chk($sformatf("v%0d rf_sel", n), 32'(rf_sel), ew ? 32'd0 : 32'(ea));
        chk($sformatf("v%0d rf_waddr", n), 32'(rf_waddr), ew ? 32'(ea) : 32'd0);
        chk($sformatf("v%0d rf_wdata", n), 32'(rf_wdata), ew ? 32'(ed) : 32'd0);
        req = '0;
        @(negedge clk);
        chk($sformatf("v%0d ack", n), 32'(ack), 32'(eg));
        chk($sformatf("v%0d gnt_done", n), 32'(gnt), 32'(eg));
        chk($sformatf("v%0d rf_idle", n), 32'({rf_we, rf_read_enable, rf_sel}), 32'd0);
        chk($sformatf("v%0d rdata", n), 32'(rdata), 32'(v.rdata));
        @(negedge clk);
        chk($sformatf("v%0d idle", n), 32'({gnt, ack}), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; init_bank = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;

        vecs[0] = mk(3'b001, 3'b000, {3'd0, 3'd0, 3'd5}, 24'h0,        0, 8'hA7);
        vecs[1] = mk(3'b010, 3'b010, {3'd0, 3'd2, 3'd0}, 24'h003C00,   1, 8'hA7);
        vecs[2] = mk(3'b001, 3'b000, {3'd0, 3'd0, 3'd2}, 24'h0,        0, 8'h3C);
        vecs[3] = mk(3'b100, 3'b000, {3'd7, 3'd0, 3'd0}, 24'h0,        2, 8'h78);
        vecs[4] = mk(3'b101, 3'b000, {3'd3, 3'd0, 3'd1}, 24'h0,        0, 8'h1E);
        vecs[5] = mk(3'b101, 3'b000, {3'd3, 3'd0, 3'd1}, 24'h0,        2, 8'h3C);
        vecs[6] = mk(3'b110, 3'b010, {3'd0, 3'd3, 3'd0}, 24'h005A00,   1, 8'h3C);
        vecs[7] = mk(3'b011, 3'b000, {3'd0, 3'd0, 3'd3}, 24'h0,        0, 8'h5A);

        repeat (2) @(negedge clk);
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        chk("reset rf", 32'({rf_sel, rf_read_enable, rf_we, rf_waddr, rf_wdata}), 32'd0);
        init_bank = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Request withdrawn and address changed during ACCESS.
        req = 3'b001; we = 3'b000; addr = {3'd0, 3'd0, 3'd4};
        @(negedge clk);
        chk("edge gnt", 32'(gnt), 32'd1);
        req = 3'b000; addr = {3'd0, 3'd0, 3'd6};
        #1;
        chk("edge rf_sel", 32'(rf_sel), 32'd4);
        @(negedge clk);
        chk("edge ack", 32'(ack), 32'd1);
        chk("edge rdata", 32'(rdata), 32'h4B);
        @(negedge clk);
        chk("edge idle", 32'({gnt, ack}), 32'd0);

        // Reset asserted during the ACCESS cycle of a write.
        req = 3'b010; we = 3'b010; addr = {3'd0, 3'd6, 3'd0}; wdata = 24'h009900;
        @(negedge clk);
        chk("rst_wr rf_we_before", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr gnt", 32'(gnt), 32'd0);
        chk("rst_wr ack", 32'(ack), 32'd0);
        chk("rst_wr rf_we", 32'(rf_we), 32'd0);
        req = '0; we = '0; wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_wr quiet%0d", i), 32'({gnt, ack, rf_we}), 32'd0);
        end
        chk("rst_wr bank6", 32'(bank[6]), 32'h69);
        req = 3'b101; addr = {3'd1, 3'd0, 3'd2};
        @(negedge clk);
        chk("rst_wr ptr0", 32'(gnt), 32'd1);
        req = '0;
        repeat (2) @(negedge clk);

        // Full contention from reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b111; we = 3'b000; addr = {3'd3, 3'd2, 3'd1};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk($sformatf("cont%0d gnt", t), 32'(gnt), 32'(3'b001 << (t % 3)));
            @(negedge clk);
            chk($sformatf("cont%0d ack", t), 32'(ack), 32'(3'b001 << (t % 3)));
            chk($sformatf("cont%0d onehot", t), 32'($countones(gnt)), 32'd1);
            @(negedge clk);
            chk($sformatf("cont%0d idle", t), 32'({gnt, ack}), 32'd0);
        end
        req = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
